// File: rtl/instr_encode_loader_if.sv
// Request handshake for the instruction encoder/loader: one decoded
// RV32I instruction description per valid/ready transfer.
interface instr_encode_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;

    modport master (
        output req_valid, req_kind, rd, rs1, rs2,
        output funct3, funct7, imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_kind, rd, rs1, rs2,
        input  funct3, funct7, imm,
        output req_ready
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into RV32I words, range-checks the
// immediate and streams accepted words into imem at consecutive addresses.
module instr_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    instr_encode_loader_if.slave  req,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] ADR_ONE = 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WRITE,
        FULL
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        kind_q, kind_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [2:0]        f3_q, f3_d;
    logic [6:0]        f7_q, f7_d;
    logic [20:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] word;
    logic        word_ok;
    logic        fits12;
    logic        fits13;
    logic        is_r, is_ld, is_ai, is_st, is_br, is_jal;
    logic        full_w;
    logic        ready_w;
    logic        we_w;

    assign is_r   = (kind_q == 3'd0);
    assign is_ld  = (kind_q == 3'd1);
    assign is_ai  = (kind_q == 3'd2);
    assign is_st  = (kind_q == 3'd3);
    assign is_br  = (kind_q == 3'd4);
    assign is_jal = (kind_q == 3'd5);

    // Sign-extension tests: every bit above the field width equals the sign.
    assign fits12 = (&imm_q[20:11]) | ~(|imm_q[20:11]);
    assign fits13 = (&imm_q[20:12]) | ~(|imm_q[20:12]);

    always_comb begin
        word    = '0;
        word_ok = 1'b0;
        unique case (1'b1)
            is_r: begin
                word    = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OP_R};
                word_ok = 1'b1;
            end
            is_ld: begin
                word    = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
                word_ok = fits12;
            end
            is_ai: begin
                word    = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_ALUI};
                word_ok = fits12;
            end
            is_st: begin
                word    = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                           imm_q[4:0], OP_STORE};
                word_ok = fits12;
            end
            is_br: begin
                word    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                           imm_q[4:1], imm_q[11], OP_BRANCH};
                word_ok = fits13 & ~imm_q[0];
            end
            is_jal: begin
                word    = {imm_q[20], imm_q[10:1], imm_q[11],
                           imm_q[19:12], rd_q, OP_JAL};
                word_ok = ~imm_q[0];
            end
            default: begin
                word    = '0;
                word_ok = 1'b0;
            end
        endcase
    end

    assign full_w = (count_q == DEPTH_V);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        imm_d   = imm_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        ready_w = 1'b0;
        we_w    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_w = ~full_w;
                if (req.req_valid && ready_w) begin
                    kind_d  = req.req_kind;
                    rd_d    = req.rd;
                    rs1_d   = req.rs1;
                    rs2_d   = req.rs2;
                    f3_d    = req.funct3;
                    f7_d    = req.funct7;
                    imm_d   = req.imm;
                    state_d = ENC;
                end
            end
            ENC: begin
                if (word_ok) begin
                    wdata_d = word;
                    state_d = WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                we_w    = 1'b1;
                addr_d  = addr_q + ADR_ONE;
                count_d = count_q + CNT_ONE;
                state_d = (count_d == DEPTH_V) ? FULL : IDLE;
            end
            FULL: begin
                ready_w = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Restart wins over any transfer or pending write this cycle.
        if (clear) begin
            state_d = IDLE;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            wdata_d = '0;
            we_w    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            imm_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    assign req.req_ready = ready_w;
    assign imem_we       = we_w;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign count         = count_q;
    assign full          = full_w;
    assign err           = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed cases, random requests checked
// against an arithmetic reference, and a 4-deep instance for fill/wrap.
module tb_instr_encode_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    bit   sel = 1'b0;

    always #5 clk = ~clk;

    logic        v_valid = 1'b0;
    logic [2:0]  v_kind = '0;
    logic [4:0]  v_rd = '0, v_rs1 = '0, v_rs2 = '0;
    logic [2:0]  v_f3 = '0;
    logic [6:0]  v_f7 = '0;
    logic [20:0] v_imm = '0;

    instr_encode_loader_if ifa ();
    instr_encode_loader_if ifb ();

    assign ifa.req_valid = v_valid & ~sel;
    assign ifb.req_valid = v_valid & sel;
    assign ifa.req_kind = v_kind;
    assign ifb.req_kind = v_kind;
    assign ifa.rd = v_rd;
    assign ifb.rd = v_rd;
    assign ifa.rs1 = v_rs1;
    assign ifb.rs1 = v_rs1;
    assign ifa.rs2 = v_rs2;
    assign ifb.rs2 = v_rs2;
    assign ifa.funct3 = v_f3;
    assign ifb.funct3 = v_f3;
    assign ifa.funct7 = v_f7;
    assign ifb.funct7 = v_f7;
    assign ifa.imm = v_imm;
    assign ifb.imm = v_imm;

    logic        we_a, full_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;
    logic        we_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    instr_encode_loader #(.ADDR_W(8)) u_big (
        .clk(clk), .rst(rst), .clear(clear), .req(ifa.slave),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .count(count_a), .full(full_a), .err(err_a)
    );

    instr_encode_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .clear(clear), .req(ifb.slave),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .count(count_b), .full(full_b), .err(err_b)
    );

    logic        we_s, full_s, err_s, rdy;
    logic [7:0]  addr_s;
    logic [31:0] wdata_s;
    logic [8:0]  cnt_s;

    always_comb begin
        we_s = we_a; addr_s = addr_a; wdata_s = wdata_a;
        cnt_s = count_a; full_s = full_a; err_s = err_a;
        rdy = ifa.req_ready;
        if (sel) begin
            we_s = we_b; addr_s = {6'b0, addr_b}; wdata_s = wdata_b;
            cnt_s = {6'b0, count_b}; full_s = full_b; err_s = err_b;
            rdy = ifb.req_ready;
        end
    end

    int checks = 0;
    int errors = 0;

    int m_addr[2];
    int m_count[2];
    bit m_err[2];
    int depth[2] = '{256, 4};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 0; m_count[i] = 0; m_err[i] = 1'b0;
        end
    endfunction

    // Reference: legality from the numeric value of the immediate.
    function automatic logic [31:0] ref_enc(
        input logic [2:0] k, input logic [4:0] d, s1, s2,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [20:0] im, output bit ok);
        int s;
        s = $signed(im);
        ok = 1'b0;
        ref_enc = '0;
        case (k)
            3'd0: begin ok = 1'b1; ref_enc = {f7, s2, s1, f3, d, 7'h33}; end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                ref_enc = {im[11:0], s1, f3, d, 7'h03};
            end
            3'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                ref_enc = {im[11:0], s1, f3, d, 7'h13};
            end
            3'd3: begin
                ok = (s >= -2048) && (s <= 2047);
                ref_enc = {im[11:5], s2, s1, f3, im[4:0], 7'h23};
            end
            3'd4: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
                ref_enc = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
            end
            3'd5: begin
                ok = (s % 2 == 0);
                ref_enc = {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic accept_req(
        input logic [2:0] k, input logic [4:0] d, s1, s2,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [20:0] im, output bit acc);
        int n;
        @(negedge clk);
        v_kind = k; v_rd = d; v_rs1 = s1; v_rs2 = s2;
        v_f3 = f3; v_f7 = f7; v_imm = im; v_valid = 1'b1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = rdy;
        if (!acc) chk("rdy_timeout", rdy, 1);
        else @(posedge clk);
        #1 v_valid = 1'b0;
    endtask

    task automatic do_req(
        input logic [2:0] k, input logic [4:0] d, s1, s2,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [20:0] im, output logic [31:0] wd);
        bit ok, acc;
        logic [31:0] w;
        int x;
        x = sel ? 1 : 0;
        w = ref_enc(k, d, s1, s2, f3, f7, im, ok);
        wd = '0;
        accept_req(k, d, s1, s2, f3, f7, im, acc);
        if (!acc) return;
        @(negedge clk);
        chk("enc_we", we_s, 0);
        chk("enc_rdy", rdy, 0);
        @(negedge clk);
        if (ok) begin
            chk("wr_we", we_s, 1);
            chk("wr_addr", addr_s, m_addr[x]);
            chk("wr_data", wdata_s, w);
            wd = wdata_s;
            m_addr[x] = (m_addr[x] + 1) % depth[x];
            m_count[x]++;
            @(negedge clk);
            chk("post_we", we_s, 0);
        end else begin
            m_err[x] = 1'b1;
            chk("bad_we", we_s, 0);
        end
        chk("cnt", cnt_s, m_count[x]);
        chk("addr", addr_s, m_addr[x]);
        chk("err", err_s, m_err[x]);
        chk("full", full_s, m_count[x] == depth[x]);
        chk("rdy", rdy, m_count[x] != depth[x]);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_zero();
        chk("clr_cnt", cnt_s, 0);
        chk("clr_addr", addr_s, 0);
        chk("clr_err", err_s, 0);
        chk("clr_full", full_s, 0);
        chk("clr_rdy", rdy, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, rdy, 1);
        chk({tag, "_we"}, we_s, 0);
        chk({tag, "_addr"}, addr_s, 0);
        chk({tag, "_wdata"}, wdata_s, 0);
        chk({tag, "_cnt"}, cnt_s, 0);
        chk({tag, "_full"}, full_s, 0);
        chk({tag, "_err"}, err_s, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd;
        logic [2:0]  k;
        logic [20:0] im;
        int          v;
        bit          acc;
        int          bnd[10] = '{2047, 2048, -2048, -2049, 4094,
                                 4096, -4096, -4098, 1, 0};

        model_zero();
        repeat (2) @(negedge clk);
        sel = 1'b0;
        chk_reset_vals("rst_a");
        sel = 1'b1;
        #1 chk_reset_vals("rst_b");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, wd);
        chk("tp_r", wd, 32'h002081B3);
        do_req(3'd2, 5'd5, 5'd0, 5'd9, 3'd0, 7'h55, 21'h1FFFFF, wd);
        chk("tp_alui", wd, 32'hFFF00293);
        do_req(3'd3, 5'd7, 5'd1, 5'd2, 3'd2, 7'd0, 21'd8, wd);
        chk("tp_store", wd, 32'h0020A423);
        do_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFFC, wd);
        chk("tp_branch", wd, 32'hFE208EE3);
        do_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'd6000, wd);
        chk("tp_br_err", err_s, 1);
        chk("tp_br_addr", addr_s, 4);
        do_req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd3, wd);
        do_req(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 21'd0, wd);
        chk("tp_k7_cnt", cnt_s, 4);
        do_clear();

        for (int i = 0; i < 60; i++) begin
            k = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: im = 21'($urandom);
                1: begin
                    v = int'($urandom_range(0, 8191)) - 4096;
                    im = v[20:0];
                end
                2: begin
                    v = bnd[$urandom_range(0, 9)];
                    im = v[20:0];
                end
                default: begin
                    v = (int'($urandom_range(0, 2047)) - 1024) * 2;
                    im = v[20:0];
                end
            endcase
            do_req(k, 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), 7'($urandom), im, wd);
            if ($urandom_range(0, 19) == 0) do_clear();
        end

        do_req(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 21'd0, wd);
        accept_req(3'd0, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 21'd0, acc);
        @(negedge clk);
        clear = 1'b1;
        #1 chk("ce_we", we_s, 0);
        @(negedge clk);
        clear = 1'b0;
        model_zero();
        chk_reset_vals("ce");
        @(negedge clk);
        chk("ce_we2", we_s, 0);
        chk("ce_cnt2", cnt_s, 0);

        do_req(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 21'd0, wd);
        accept_req(3'd1, 5'd4, 5'd5, 5'd6, 3'd2, 7'd0, 21'd4, acc);
        @(negedge clk);
        @(negedge clk);
        chk("rw_we_pre", we_s, 1);
        #1 rst = 1'b1;
        #1 model_zero();
        chk_reset_vals("rw");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_we2", we_s, 0);
        chk("rw_cnt2", cnt_s, 0);

        sel = 1'b1;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            do_req(3'd0, 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), 7'($urandom), 21'd0, wd);
        end
        chk("sm_full", full_s, 1);
        chk("sm_rdy", rdy, 0);
        @(negedge clk);
        v_kind = 3'd0;
        v_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("sm_fifth_we", we_s, 0);
        end
        v_valid = 1'b0;
        chk("sm_fifth_cnt", cnt_s, 4);
        chk("sm_fifth_addr", addr_s, 0);
        do_clear();
        do_req(3'd0, 5'd9, 5'd8, 5'd7, 3'd1, 7'd0, 21'd0, wd);
        chk("sm_wrap_cnt", cnt_s, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
